sha1_message_schedule: RTL
==========================

// Module: sha1_message_schedule
// PURPOSE
//  Expands one 512-bit SHA-1 block into the 80-word W[t] sequence, one word per accepted round.
//  - Upstream: the message collector supplies the 512-bit base message, with the counter already inserted.
//  - Downstream: the SHA-1 round datapath inside each collision searcher consumes W[t].
//  - Storage: a 16-word sliding window replaces an 80-word array.
// PARAMETERS
//  ROUNDS   80  total words emitted per block (t = 0..ROUNDS-1); must be >16 and <=128
//  ROUND_W  7   width of round index output; must hold ROUNDS-1
// PORTS
//  clk      in   1        rising-edge clock (caller gates with clk_en upstream)
//  reset    in   1        asynchronous, active-low reset
//  load     in   1        1-cycle pulse: capture message, begin new schedule
//  message  in   512      block; word 0 = message[511:480], word 15 = message[31:0]
//  advance  in   1        consumer took current w this cycle; step to next round
//  w        out  32       current schedule word W[round]
//  round    out  ROUND_W  index t of w
//  valid    out  1        w/round meaningful (state RUN)
//  last     out  1        valid && round == ROUNDS-1
//  done     out  1        1-cycle pulse after final word accepted
// BEHAVIOUR
//  Reset (reset==0, async):
//   - State=IDLE; all 16 window regs, round, valid, last, done = 0; w = 0.
//  Storage:
//   - buf[0..15] x 32b; invariant in RUN: buf[k] = W[round+k]; w = buf[0] (combinational from reg).
//  Load:
//   - load==1 at edge: buf[k] <= message[511-32k -: 32], round <= 0, state <= RUN.
//   - valid=1 the cycle after load (latency 1); first w = word 0.
//  Advance (RUN, advance==1, load==0):
//   - buf[k] <= buf[k+1] for k=0..14.
//   - buf[15] <= ROTL1(buf[13]^buf[8]^buf[2]^buf[0]) (= W[t+16] per FIPS 180-4); round <= round+1.
//   - Throughput 1 word/cycle with advance held high.
//  Stall:
//   - RUN with advance==0: all regs hold; w/round stable indefinitely.
//  Completion:
//   - advance while last==1: state <= IDLE, valid <= 0, round <= 0, done <= 1 for exactly one cycle.
//   - Window contents after completion are don't-care but must not X-propagate: hold them.
//  FSM: IDLE --load--> RUN; RUN --load--> RUN (restart); RUN --advance&last--> IDLE.
//  Simultaneous / boundary:
//   - load && advance in RUN: load wins; advance ignored; schedule restarts at round 0 from new message; no done.
//   - load on the same edge as final advance: load wins, done stays 0, state RUN.
//   - advance in IDLE: ignored; no state change, no done.
//   - load while done pulsing: accepted normally; done still deasserts next cycle.
//   - Reset mid-RUN: immediate IDLE, valid=0; no done pulse; partial schedule discarded.
//  Arithmetic:
//   - All XOR/rotate is 32-bit, no carries; ROTL1(x) = {x[30:0], x[31]}.
//   - round never wraps: it stops at ROUNDS-1 and clears to 0 on completion.
//  message need only be stable on the load edge; it is sampled once.
// TESTING
//  T1 reset: assert reset=0 mid-stream -> valid=0,w=0,round=0,done=0 immediately (async); release -> IDLE held.
//  T2 "abc" block (msg word0=32'h61626380, words1-14=0, word15=32'h00000018), advance held 1 ->
//     W0=61626380, W15=00000018, W16=C2C4C700, W17=00000000, W18=00000030;
//     all 80 words match C model; last on round 79; done 1 cycle later for 1 cycle.
//  T3 stalls: same block, advance random 30% duty -> identical W sequence vs T2, w stable during stalls, no done until 80th accept.
//  T4 restart: load block A, advance to round 40, then load block B with advance=1 same cycle
//     -> round=0, w=B word0, full B sequence follows, no done from A.
//  T5 idle noise: advance pulses in IDLE -> no valid, no done; then load+80 advances -> exactly one done pulse.
//  T6 back-to-back: load asserted on the cycle done pulses -> next block starts (valid=1, round=0) with no lost cycle, both schedules correct.

Source files
------------

// File: rtl/sha1_message_schedule.sv
// SHA-1 message schedule: expands one 512-bit block into W[0..ROUNDS-1], one word per
// accepted round, using a 16-word sliding window instead of a full ROUNDS-word array.
module sha1_message_schedule #(
   parameter int ROUNDS  = 80,
   parameter int ROUND_W = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [511:0]       message,
   input  logic               advance,
   output logic [31:0]        w,
   output logic [ROUND_W-1:0] round,
   output logic               valid,
   output logic               last,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } stateT;

   localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(ROUNDS - 1);

   stateT              stateReg, stateNext;
   logic [ROUND_W-1:0] roundReg, roundNext;
   logic               doneReg, doneNext;
   logic               loadWin, shiftWin;
   logic               isLast;

   logic [31:0] windowReg [16];
   logic [31:0] loadWord  [16];
   logic [31:0] shiftWord [16];
   logic [31:0] mixWord;
   logic [31:0] expandWord;

   assign isLast = (stateReg == RUN) && (roundReg == LastRound);

   // W[t+16] = ROTL1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]) relative to the window head
   assign mixWord    = windowReg[13] ^ windowReg[8] ^ windowReg[2] ^ windowReg[0];
   assign expandWord = {mixWord[30:0], mixWord[31]};

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi = gi + 1) begin : gWindow
         assign loadWord[gi] = message[511 - 32*gi -: 32];
         if (gi < 15) begin : gShift
            assign shiftWord[gi] = windowReg[gi + 1];
         end else begin : gTail
            assign shiftWord[gi] = expandWord;
         end
      end
   endgenerate

   // A load always wins; the final accept returns to IDLE without shifting the window
   always_comb begin
      stateNext = stateReg;
      roundNext = roundReg;
      doneNext  = 1'b0;
      loadWin   = 1'b0;
      shiftWin  = 1'b0;
      if (load) begin
         stateNext = RUN;
         roundNext = '0;
         loadWin   = 1'b1;
      end else if ((stateReg == RUN) && advance) begin
         if (isLast) begin
            stateNext = IDLE;
            roundNext = '0;
            doneNext  = 1'b1;
         end else begin
            shiftWin  = 1'b1;
            roundNext = roundReg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg <= IDLE;
         roundReg <= '0;
         doneReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         roundReg <= roundNext;
         doneReg  <= doneNext;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 16; k++) begin
            windowReg[k] <= '0;
         end
      end else if (loadWin) begin
         windowReg <= loadWord;
      end else if (shiftWin) begin
         windowReg <= shiftWord;
      end
   end

   assign w     = windowReg[0];
   assign round = roundReg;
   assign valid = (stateReg == RUN);
   assign last  = isLast;
   assign done  = doneReg;

endmodule
